// File: rtl/result_byte_serializer.sv
// result_byte_serializer
// Captures a WIDTH-bit word on start and streams it MSB-first as bytes over a
// valid/ready interface. After the data bytes it sends one XOR checksum byte,
// marked with out_last. The word is zero-padded at the top up to whole bytes.
module result_byte_serializer #(
  parameter int WIDTH = 196
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       checksum
);

  // Number of bytes needed to hold w bits.
  function automatic int calc_beats(input int w);
    return (w + 7) / 8;
  endfunction

  localparam int BEATS = calc_beats(WIDTH);
  localparam int SW    = BEATS * 8;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] shreg;
  logic [CW-1:0] cnt;
  logic          hs;
  logic          take;

  assign hs   = out_valid && out_ready;
  assign take = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: advance only on start in IDLE or on an accepted beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: if (hs && cnt == LAST_CNT) state_nxt = CSUM;
      CSUM: if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream outputs are pure functions of state and registers, so they hold
  // steady for as long as the consumer stalls.
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        out_data  = shreg[SW-1 -: 8];
        busy      = 1'b1;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = checksum;
        out_last  = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture on start, shift/accumulate on each data handshake,
  // pulse done the cycle after the checksum beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      checksum <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= (state == CSUM) && hs;
      if (take) begin
        shreg    <= SW'(data_in);
        cnt      <= '0;
        checksum <= 8'h00;
      end else if (state == SEND && hs) begin
        shreg    <= shreg << 8;
        cnt      <= cnt + CW'(1);
        checksum <= checksum ^ shreg[SW-1 -: 8];
      end
    end
  end

endmodule
